matriz_varredura: RTL
=====================

Name: matriz_varredura

Overview:
- Time-multiplexed scan driver for the 5-column x 7-row LED matrix; drives column selects C1..C5 and row lines L1..L7.
- Holds one 35-bit frame and a shadow frame. New frames are adopted only at frame boundaries, so the display never tears.
- Sits between the pattern/encoder logic, which supplies FRAME_IN and LOAD, and the matrix pins. Replaces static column wiring once more than one column must show distinct data.

Parameters:
- DIV, 50000: clock cycles per column slot; legal range is 2 or more.
- BLANK, 2: cycles at the start of each slot with all columns off (anti-ghosting); must satisfy BLANK < DIV.
- COL_ACT_LOW, 1: 1 means an active column is driven 0; 0 means it is driven 1.
- ROW_ACT_LOW, 0: 1 means a lit row is driven 0; 0 means it is driven 1.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- EN  in  1  scan enable; 0 blanks the display
- FRAME_IN  in  35  pixel data, column-major: bits [7c+6:7c] = column c (c=0 is C1), bit 7c = row L1
- LOAD  in  1  single-cycle strobe; captures FRAME_IN into the shadow register
- LOAD_ACK  out  1  one-cycle pulse when the shadow frame becomes the active frame
- FRAME_SYNC  out  1  one-cycle pulse in the first cycle of column 0
- C  out  5  column selects, C[0]=C1 .. C[4]=C5
- L  out  7  row lines, L[0]=L1 .. L[6]=L7

Behaviour:
- Reset (asynchronous, RST=1):
  - State IDLE; prescaler=0, col=0.
  - Active and shadow frames = 0; pending=0.
  - C = all inactive, L = all unlit, LOAD_ACK=0, FRAME_SYNC=0.
- All outputs are registered; a change of state or column appears on the pins on the next clock edge.
- States: IDLE, BLANK, DRIVE.
  - IDLE: outputs inactive. When EN=1, go to BLANK with col=0 and prescaler=0.
  - BLANK: C inactive, L unlit. After BLANK cycles, go to DRIVE.
  - DRIVE: C[col] active, all other columns inactive; L = active frame bits [7col+6:7col], polarity applied.
  - Slot end: when prescaler reaches DIV-1, set prescaler=0, col = col+1 (4 wraps to 0), go to BLANK.
- Slot length is exactly DIV cycles: BLANK cycles blanked, then DIV-BLANK cycles driven.
- Frame boundary is every entry into column 0, whether from the 4->0 wrap or from IDLE.
  - FRAME_SYNC pulses in the first BLANK cycle of column 0.
  - If pending=1: active <= shadow, pending <= 0, LOAD_ACK pulses in the same cycle as FRAME_SYNC.
- LOAD=1: shadow <= FRAME_IN, pending <= 1. The latest LOAD wins; earlier unadopted frames are silently dropped.
- LOAD in the same cycle as a boundary transfer: the transfer uses the old shadow; the new data is captured and pending stays 1 for the next frame.
- LOAD is accepted in every state, including IDLE.
- EN deasserted: in the next cycle, go to IDLE with outputs inactive, prescaler=0, col=0. Active frame, shadow and pending are retained.
- EN reasserted: scanning restarts at column 0, slot start.
- RST mid-slot or mid-frame: immediate return to the reset values above; any pending frame is lost.
- Prescaler is ceil(log2(DIV)) bits wide and never exceeds DIV-1. Column counter is 3 bits; values 5-7 are unreachable and treated as 0.

Decomposition:
- Shared package matriz_pkg:
  - N_COL=5, N_ROW=7, FRAME_W=35.
  - State encoding IDLE/BLANK/DRIVE.
  - Polarity helper constants.
- One natural sub-module: matriz_prescaler. It is a parameterised DIV counter with a synchronous clear, and outputs the slot-end tick plus a blank-window flag.
- The top level holds the FSM, the column counter, and the frame/shadow registers.

Test Plan (DIV=4, BLANK=1, COL_ACT_LOW=1, ROW_ACT_LOW=0):
- Reset then EN=1, frame all 0:
  - C sequence 11111, 11110 for 3 cycles, 11111, 11101, and so on, with one column active per slot.
  - FRAME_SYNC pulses every 20 cycles.
- LOAD with FRAME_IN=35'h0000_0007F (column 0 rows all lit) during column 2:
  - LOAD_ACK coincides with the next FRAME_SYNC.
  - Thereafter L=7'h7F only while C=11110, and L=0 otherwise.
- Two LOADs (A then B) within one frame:
  - Only one LOAD_ACK; the displayed frame is B.
- LOAD asserted in the same cycle as FRAME_SYNC:
  - The old shadow is adopted now; the new data is adopted at the following boundary with a second LOAD_ACK.
- EN=0 mid-column 3:
  - Next cycle C=11111 and L=0.
  - EN=1 later: scanning restarts at column 0 with FRAME_SYNC; the frame is unchanged.
- RST pulsed asynchronously mid-DRIVE:
  - Outputs go inactive without waiting for a clock edge.
  - Active frame reads back 0, shown by L=0 in every column after restart.

Source files
------------

// File: rtl/matriz_pkg.sv
// Shared constants and state encoding for the 5x7 LED matrix scan driver.
package matriz_pkg;

    localparam int N_COL   = 5;
    localparam int N_ROW   = 7;
    localparam int FRAME_W = N_COL * N_ROW;

    // Highest legal column index; the 3-bit counter wraps from here to 0.
    localparam logic [2:0] LAST_COL = 3'(N_COL - 1);

    // Idle (inactive / unlit) pin level for each polarity choice.
    localparam logic POL_ACT_HIGH_IDLE = 1'b0;
    localparam logic POL_ACT_LOW_IDLE  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    // Pin level that means "off" for a line of the given polarity.
    function automatic logic idle_level(input bit act_low);
        return act_low ? POL_ACT_LOW_IDLE : POL_ACT_HIGH_IDLE;
    endfunction

endpackage

// File: rtl/matriz_prescaler.sv
// Column-slot prescaler: counts 0..DIV-1 while running, flags slot end and
// the last cycle of the anti-ghosting blank window.
module matriz_prescaler #(
    parameter int DIV   = 50000,
    parameter int BLANK = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic blank_last
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST_CNT  = W'(DIV - 1);
    localparam logic [W-1:0] BLANK_END = W'(BLANK - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick       = (cnt_q == LAST_CNT);
    assign blank_last = (BLANK > 0) && (cnt_q == BLANK_END);

    // Next count: held at 0 while cleared, wraps at DIV-1 so it never exceeds it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) cnt_d = '0;
        else             cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/matriz_varredura.sv
// Time-multiplexed 5-column x 7-row LED matrix scan driver with a shadow
// frame that is only adopted at frame boundaries (entry into column 0).
module matriz_varredura
    import matriz_pkg::*;
#(
    parameter int DIV         = 50000,
    parameter int BLANK       = 2,
    parameter bit COL_ACT_LOW = 1'b1,
    parameter bit ROW_ACT_LOW = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic [FRAME_W-1:0] FRAME_IN,
    input  logic               LOAD,
    output logic               LOAD_ACK,
    output logic               FRAME_SYNC,
    output logic [N_COL-1:0]   C,
    output logic [N_ROW-1:0]   L
);
    localparam logic [N_COL-1:0] C_OFF = {N_COL{idle_level(COL_ACT_LOW)}};
    localparam logic [N_ROW-1:0] L_OFF = {N_ROW{idle_level(ROW_ACT_LOW)}};
    // With no blank window a slot starts directly in DRIVE.
    localparam state_e START_ST = (BLANK > 0) ? ST_BLANK : ST_DRIVE;

    state_e             state_q, state_d;
    logic [2:0]         col_q, col_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic [N_COL-1:0]   c_q, c_d;
    logic [N_ROW-1:0]   l_q, l_d;
    logic               sync_q, sync_d;
    logic               ack_q, ack_d;

    logic               boundary;
    logic               cnt_clr;
    logic               tick;
    logic               blank_last;

    matriz_prescaler #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_presc (
        .clk        (CLK),
        .rst        (RST),
        .clr        (cnt_clr),
        .tick       (tick),
        .blank_last (blank_last)
    );

    // Scan FSM: state, column and frame-boundary detection.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        boundary = 1'b0;
        cnt_clr  = 1'b0;
        if (!EN) begin
            state_d = ST_IDLE;
            col_d   = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d  = START_ST;
                    col_d    = '0;
                    boundary = 1'b1;
                    cnt_clr  = 1'b1;
                end
                ST_BLANK: begin
                    if (blank_last) state_d = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (tick) begin
                        state_d = START_ST;
                        // 5..7 are unreachable; treat them like the last column so they wrap to 0.
                        if (col_q >= LAST_COL) begin
                            col_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // Frame buffering: latest LOAD wins; boundary transfer uses the pre-LOAD shadow.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        active_d  = active_q;
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (LOAD) begin
            shadow_d  = FRAME_IN;
            pending_d = 1'b1;
        end
    end

    // Pin values for the upcoming cycle, derived from next state so pins track state.
    always_comb begin
        logic [N_COL-1:0] c_act;
        logic [N_ROW-1:0] rows;
        c_act  = '0;
        rows   = '0;
        sync_d = boundary;
        ack_d  = boundary && pending_q;
        if (state_d == ST_DRIVE) begin
            for (int c = 0; c < N_COL; c++) begin
                if (int'(col_d) == c || (c == 0 && col_d > LAST_COL)) begin
                    c_act[c] = 1'b1;
                    rows     = active_d[N_ROW*c +: N_ROW];
                end
            end
        end
        c_d = c_act ^ C_OFF;
        l_d = rows ^ L_OFF;
    end

    // State, frame and registered output flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            c_q       <= C_OFF;
            l_q       <= L_OFF;
            sync_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            c_q       <= c_d;
            l_q       <= l_d;
            sync_q    <= sync_d;
            ack_q     <= ack_d;
        end
    end

    assign C          = c_q;
    assign L          = l_q;
    assign FRAME_SYNC = sync_q;
    assign LOAD_ACK   = ack_q;

endmodule
